// File: rtl/debug_seq_pkg.sv
// Shared op codes, status bit positions, FSM state encodings and sequencing rules
// for the debug status register sequencer.
package debug_seq_pkg;

    localparam logic [1:0] OP_STATUS     = 2'd0;
    localparam logic [1:0] OP_HALT       = 2'd1;
    localparam logic [1:0] OP_RESUME     = 2'd2;
    localparam logic [1:0] OP_RESET_HALT = 2'd3;

    localparam int BIT_DBG_REQ = 0;
    localparam int BIT_DBG_ACK = 1;
    localparam int BIT_RST_REQ = 2;
    localparam int BIT_HALTED  = 3;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE        = 4'd0;
    localparam state_t ST_RD_SETUP    = 4'd1;
    localparam state_t ST_RD_ACCESS   = 4'd2;
    localparam state_t ST_WR_SETUP    = 4'd3;
    localparam state_t ST_WR_ACCESS   = 4'd4;
    localparam state_t ST_GAP         = 4'd5;
    localparam state_t ST_POLL_SETUP  = 4'd6;
    localparam state_t ST_POLL_ACCESS = 4'd7;
    localparam state_t ST_RESP        = 4'd8;

    // DBG_REQ is toggle-on-write, so the write only carries bit0 when it must flip.
    function automatic logic [7:0] write_value(input logic [1:0] op, input logic dbg_req);
        logic [7:0] w;
        w = 8'h00;
        case (op)
            OP_HALT:       w[BIT_DBG_REQ] = ~dbg_req;
            OP_RESUME:     w[BIT_DBG_REQ] = dbg_req;
            OP_RESET_HALT: begin
                w[BIT_DBG_REQ] = ~dbg_req;
                w[BIT_RST_REQ] = 1'b1;
            end
            default:       w = 8'h00;
        endcase
        return w;
    endfunction

    function automatic logic poll_done(input logic [1:0] op, input logic [3:0] s);
        logic d;
        case (op)
            OP_HALT:       d = s[BIT_HALTED] & s[BIT_DBG_ACK];
            OP_RESUME:     d = ~s[BIT_HALTED] & ~s[BIT_DBG_REQ];
            OP_RESET_HALT: d = ~s[BIT_RST_REQ] & s[BIT_HALTED] & s[BIT_DBG_REQ];
            default:       d = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/debug_sequencer_apb.sv
// Single-transfer APB engine: start launches SETUP next cycle, ACCESS holds until PREADY.
// A start coincident with done re-enters SETUP, so PENABLE always drops for a cycle.
module apb_master_port #(
    parameter logic [4:0] ADDR = 5'h00
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       start,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);

    assign done  = PSEL & PENABLE & PREADY;
    assign rdata = PRDATA;
    assign PADDR = ADDR;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= 8'h00;
        end else if (start) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= write;
            if (write)
                PWDATA <= wdata;
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else if (done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_sequencer.sv
// Host command sequencer driving the debug status register over APB (read, optional RMW, poll).
// One command in flight; cmd_ready only in IDLE, PREADY stalls are absorbed without limit.
module debug_sequencer
    import debug_seq_pkg::*;
#(
    parameter logic [4:0] STATUS_ADDR = 5'h00,
    parameter int         POLL_GAP    = 4,
    parameter int         POLL_LIMIT  = 255
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       rsp_valid,
    output logic [7:0] rsp_status,
    output logic       rsp_error,
    output logic       busy,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY
);

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [7:0] LIMIT    = 8'(POLL_LIMIT);

    state_t     state;
    logic [1:0] op;
    logic [7:0] gap_cnt;
    logic [7:0] poll_cnt;
    logic       start;
    logic       wr;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] rd_w;

    assign rd_w      = write_value(op, rdata[BIT_DBG_REQ]);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        start = 1'b0;
        wr    = 1'b0;
        case (state)
            ST_IDLE:      start = cmd_valid;
            ST_RD_ACCESS: begin
                if (done && op != OP_STATUS) begin
                    start = 1'b1;
                    wr    = (rd_w != 8'h00);
                end
            end
            ST_GAP:       start = (gap_cnt == GAP_LAST);
            default:      start = 1'b0;
        endcase
    end

    apb_master_port #(.ADDR(STATUS_ADDR)) u_apb (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .start   (start),
        .write   (wr),
        .wdata   (rd_w),
        .done    (done),
        .rdata   (rdata),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            op         <= OP_STATUS;
            gap_cnt    <= 8'h00;
            poll_cnt   <= 8'h00;
            rsp_status <= 8'h00;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op    <= cmd_op;
                        state <= ST_RD_SETUP;
                    end
                end
                ST_RD_SETUP:   state <= ST_RD_ACCESS;
                ST_RD_ACCESS: begin
                    if (done) begin
                        rsp_status <= rdata;
                        rsp_error  <= 1'b0;
                        if (op == OP_STATUS)
                            state <= ST_RESP;
                        else if (rd_w != 8'h00)
                            state <= ST_WR_SETUP;
                        else
                            state <= ST_POLL_SETUP;
                    end
                end
                ST_WR_SETUP:   state <= ST_WR_ACCESS;
                ST_WR_ACCESS: begin
                    if (done) begin
                        gap_cnt <= 8'h00;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 8'h00;
                        state   <= ST_POLL_SETUP;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                ST_POLL_SETUP: state <= ST_POLL_ACCESS;
                ST_POLL_ACCESS: begin
                    if (done) begin
                        rsp_status <= rdata;
                        poll_cnt   <= poll_cnt + 8'd1;
                        if (poll_done(op, rdata[3:0])) begin
                            rsp_error <= 1'b0;
                            state     <= ST_RESP;
                        end else if (poll_cnt + 8'd1 == LIMIT) begin
                            rsp_error <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            gap_cnt <= 8'h00;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_RESP: begin
                    poll_cnt <= 8'h00;
                    state    <= ST_IDLE;
                end
                default:       state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench: behavioural status-register slave, APB protocol monitor and transaction-level reference.
module tb_debug_sequencer;

    localparam int LIMIT = 3;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready, rsp_valid, rsp_error, busy;
    logic [7:0] rsp_status;
    logic       PSEL, PENABLE, PWRITE, PREADY;
    logic [4:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    always #5 PCLK = ~PCLK;

    debug_sequencer #(.STATUS_ADDR(5'h00), .POLL_GAP(4), .POLL_LIMIT(LIMIT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_error(rsp_error), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Status register slave: bit0 toggles on write, ACK+HALTED follow DBG_REQ after 5 cycles,
    // RST_REQ pulses 3 cycles then forces HALTED.
    logic [7:0] st = 8'h00, nx, load_val = 8'h00;
    logic       load_req = 1'b0;
    logic       stuck = 1'b0;
    int         ack_cnt = 0, rst_cnt = 0, ack_nx, rst_nx;
    int         stall_cfg = 0, wait_cnt = 0;

    assign PRDATA = st;
    assign PREADY = (wait_cnt >= stall_cfg);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    always @(posedge PCLK) begin
        nx = st;
        ack_nx = (ack_cnt > 0) ? ack_cnt - 1 : 0;
        rst_nx = (rst_cnt > 0) ? rst_cnt - 1 : 0;
        if (load_req) begin
            nx = load_val; ack_nx = 0; rst_nx = 0;
        end else begin
            if (ack_cnt == 1) begin nx[1] = 1'b1; nx[3] = 1'b1; end
            if (rst_cnt == 1) begin nx[2] = 1'b0; nx[3] = 1'b1; end
            if (!PRESET && PSEL && PENABLE && PREADY && PWRITE) begin
                if (PWDATA[0]) begin
                    nx[0] = ~st[0];
                    if (nx[0]) ack_nx = 5;
                    else begin
                        nx[1] = 1'b0; ack_nx = 0;
                        if (!stuck) nx[3] = 1'b0;
                    end
                end
                if (PWDATA[2]) begin nx[2] = 1'b1; rst_nx = 3; end
            end
        end
        st      <= nx;
        ack_cnt <= ack_nx;
        rst_cnt <= rst_nx;
    end

    // Monitor: records completed transfers and counts APB protocol violations.
    typedef struct { logic wr; logic [7:0] d; } xfer_t;
    xfer_t xq[$];
    int viol = 0, rsp_cnt = 0;
    logic prev_done = 0, prev_stall = 0, prev_setup = 0;

    always @(posedge PCLK) begin
        if (PRESET) begin
            prev_done = 0; prev_stall = 0; prev_setup = 0;
        end else begin
            if (PSEL && PENABLE && PREADY) xq.push_back('{PWRITE, PWRITE ? PWDATA : PRDATA});
            if (PSEL && PADDR != 5'h00) viol++;
            if (PWRITE && !PSEL) viol++;
            if (prev_done && PENABLE) viol++;
            if (prev_stall && !(PSEL && PENABLE)) viol++;
            if (PENABLE && !prev_setup && !prev_stall) viol++;
            prev_done  = PSEL & PENABLE & PREADY;
            prev_stall = PSEL & PENABLE & ~PREADY;
            prev_setup = PSEL & ~PENABLE;
            if (rsp_valid) rsp_cnt++;
        end
    end

    task automatic load(input logic [7:0] v);
        @(negedge PCLK); load_val = v; load_req = 1'b1;
        @(negedge PCLK); load_req = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, output int lat, output logic [7:0] rs, output logic re);
        xq.delete(); rsp_cnt = 0; viol = 0;
        @(negedge PCLK);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op;
        @(negedge PCLK);
        cmd_valid = 1'b0; lat = 1;
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
        while (!rsp_valid && lat < 3000) begin @(negedge PCLK); lat++; end
        check("rsp_wait", rsp_valid, 1);
        rs = rsp_status; re = rsp_error;
        @(negedge PCLK);
        check("rsp_one_cycle", rsp_valid, 0);
        check("rsp_status_held", rsp_status, rs);
        check("rsp_count", rsp_cnt, 1);
        check("apb_protocol", viol, 0);
    endtask

    function automatic logic want_done(input logic [1:0] op, input logic [7:0] d);
        logic dbg = d[0], ack = d[1], rst = d[2], hlt = d[3];
        case (op)
            2'd1:    return hlt && ack;
            2'd2:    return !hlt && !dbg;
            default: return !rst && hlt && dbg;
        endcase
    endfunction

    // Transaction-level reference: derive the expected bus sequence and response from the reads seen.
    task automatic ref_check(input logic [1:0] op, input logic [7:0] rs, input logic re);
        int n, idx, polls, early, wrs;
        logic [7:0] s, w;
        logic fin;
        n = xq.size();
        check("first_is_read", (n > 0 && !xq[0].wr) ? 1 : 0, 1);
        if (n > 0) begin
            s = xq[0].d;
            if (op == 2'd0) begin
                check("status_xfers", n, 1);
                check("status_data", rs, s);
                check("status_err", re, 0);
            end else begin
                w = 8'h00;
                if (op == 2'd2) w[0] = s[0]; else w[0] = !s[0];
                if (op == 2'd3) w[2] = 1'b1;
                idx = 1;
                if (w != 8'h00) begin
                    check("wr_present", (n > 1 && xq[1].wr) ? 1 : 0, 1);
                    if (n > 1) check("wr_data", xq[1].d, w);
                    idx = 2;
                end
                polls = n - idx;
                check("poll_range", (polls >= 1 && polls <= LIMIT) ? 1 : 0, 1);
                if (polls >= 1) begin
                    early = 0; wrs = 0;
                    for (int i = idx; i < n; i++) begin
                        if (xq[i].wr) wrs++;
                        if (i < n - 1 && want_done(op, xq[i].d)) early++;
                    end
                    check("poll_no_write", wrs, 0);
                    check("poll_early_done", early, 0);
                    fin = want_done(op, xq[n-1].d);
                    check("rsp_error_model", re, !fin);
                    if (!fin) check("timeout_polls", polls, LIMIT);
                    check("rsp_status_model", rs, xq[n-1].d);
                end
            end
        end
    endtask

    initial begin
        int lat, cyc;
        logic [7:0] rs;
        logic re;
        logic [1:0] op;

        repeat (3) @(negedge PCLK);
        check("rst_apb", {PSEL, PENABLE, PWRITE, PWDATA}, 11'h0);
        check("rst_rsp", {rsp_valid, rsp_error, rsp_status}, 10'h0);
        check("rst_busy_ready", {busy, cmd_ready}, 2'b01);
        PRESET = 1'b0;

        // STATUS, zero-wait slave
        stall_cfg = 0; load(8'h0A);
        run_cmd(2'd0, lat, rs, re);
        check("status_latency", lat, 3);
        check("status_0A", {re, rs}, 9'h00A);
        ref_check(2'd0, rs, re);

        // HALT from 0x00
        load(8'h00);
        run_cmd(2'd1, lat, rs, re);
        check("halt_result", {re, rs}, 9'h00B);
        check("halt_xfers", xq.size(), 3);
        ref_check(2'd1, rs, re);

        // RESET_HALT from 0x00
        load(8'h00);
        run_cmd(2'd3, lat, rs, re);
        check("rsthalt_bits", {re, rs[3], rs[2], rs[0]}, 4'b0101);
        ref_check(2'd3, rs, re);

        // RESUME with HALTED stuck: times out after LIMIT polls
        stuck = 1'b1; load(8'h0B);
        run_cmd(2'd2, lat, rs, re);
        check("resume_err", re, 1);
        check("resume_halted", rs[3], 1);
        check("resume_polls", xq.size() - 2, LIMIT);
        ref_check(2'd2, rs, re);
        stuck = 1'b0;

        // Every access stalled 4 cycles
        stall_cfg = 4; load(8'h00);
        run_cmd(2'd1, lat, rs, re);
        check("stall_halt", {re, rs}, 9'h00B);
        ref_check(2'd1, rs, re);
        load(8'h0A);
        run_cmd(2'd0, lat, rs, re);
        check("stall_status_latency", lat, 7);

        // Reset during WR_ACCESS
        load(8'h00);
        @(negedge PCLK); cmd_valid = 1'b1; cmd_op = 2'd1;
        @(negedge PCLK); cmd_valid = 1'b0; cyc = 0;
        while (!(PSEL && PENABLE && PWRITE) && cyc < 200) begin @(negedge PCLK); cyc++; end
        check("reach_wr_access", {PSEL, PENABLE, PWRITE}, 3'b111);
        rsp_cnt = 0;
        PRESET = 1'b1;
        #1;
        check("rst_drop_apb", {PSEL, PENABLE}, 2'b00);
        check("rst_rsp_status", rsp_status, 0);
        @(negedge PCLK); @(negedge PCLK); PRESET = 1'b0;
        repeat (20) @(negedge PCLK);
        check("no_rsp_after_abort", rsp_cnt + rsp_valid, 0);
        check("ready_after_abort", {cmd_ready, busy}, 2'b10);
        stall_cfg = 0; load(8'h0A);
        run_cmd(2'd0, lat, rs, re);
        check("post_rst_status", {re, rs}, 9'h00A);
        check("post_rst_latency", lat, 3);

        // Randomized commands against the reference
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            stuck = 1'($urandom_range(0, 1));
            stall_cfg = $urandom_range(0, 3);
            load(8'($urandom_range(0, 15)));
            run_cmd(op, lat, rs, re);
            ref_check(op, rs, re);
            if (op == 2'd0) check("rand_status_latency", lat, 3 + stall_cfg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
